pc_gen: RTL and testbench

- Parametrised fetch-address generator; successor to the single-register PC.
- Holds the fetch PC and selects the next one from reset vector, exception vector, exception return (EPC), pipeline redirect, return-address-stack prediction, or sequential increment.
- Drives IM and IF/ID with the current fetch address.
- Owns the EPC register and a small circular return-address stack (RAS) fed by ID-stage call/return hints.

---
 rtl/pc_gen_if.sv | 29 ++
 rtl/pc_gen.sv | 61 ++++++
 tb/tb_pc_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control requests into pc_gen and PC/RAS status back out
interface pc_gen_if #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
);
  logic                       stallIn;
  logic                       flushIn;
  logic [ADDR_W-1:0]          redirectAddrIn;
  logic                       excIn;
  logic [ADDR_W-1:0]          excEpcIn;
  logic                       eretIn;
  logic                       callIn;
  logic [ADDR_W-1:0]          callRetAddrIn;
  logic                       retPredIn;
  logic [ADDR_W-1:0]          AddrOut;
  logic [ADDR_W-1:0]          EpcOut;
  logic [$clog2(RAS_DEPTH):0] RasCountOut;
  logic                       RetPredTakenOut;
  modport master (
    output stallIn, flushIn, redirectAddrIn, excIn, excEpcIn, eretIn,
           callIn, callRetAddrIn, retPredIn,
    input  AddrOut, EpcOut, RasCountOut, RetPredTakenOut
  );
  modport slave (
    input  stallIn, flushIn, redirectAddrIn, excIn, excEpcIn, eretIn,
           callIn, callRetAddrIn, retPredIn,
    output AddrOut, EpcOut, RasCountOut, RetPredTakenOut
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with exception/EPC handling and a circular return-address stack
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC    = 32'h8000_0180,
  parameter int                INST_BYTES = 4,
  parameter int                RAS_DEPTH  = 4
) (
  input logic    clkIn,
  input logic    resetIn,
  pc_gen_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(INST_BYTES - 1);
  localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);
  logic [ADDR_W-1:0] pc, epc, rawPc, nextPc;
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]     ptr, ptrUp;
  logic [PW:0]       cnt;
  logic              retTaken, quiet, pop, push;
  // RAS only moves when nothing of higher priority claims the edge; call+ret on a non-empty stack is a replace
  always_comb begin
    quiet  = !(bus.excIn || bus.eretIn || bus.flushIn || bus.stallIn);
    pop    = quiet && bus.retPredIn && cnt != '0;
    push   = quiet && bus.callIn && !pop;
    ptrUp  = ptr + PW'(1);
    rawPc  = bus.excIn ? EXC_VEC : bus.eretIn ? epc : bus.flushIn ? bus.redirectAddrIn :
             bus.stallIn ? pc : pop ? ras[ptr] : pc + ADDR_W'(INST_BYTES);
    nextPc = rawPc & MASK;
  end
  // PC, EPC and RAS state; the stack is emptied by count only, stale entries are unreachable
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      pc       <= RESET_VEC & MASK;
      epc      <= '0;
      ptr      <= '0;
      cnt      <= '0;
      retTaken <= 1'b0;
    end else begin
      pc       <= nextPc;
      retTaken <= pop;
      if (bus.excIn) begin
        epc <= bus.excEpcIn;
        cnt <= '0;
      end else if (push) begin
        ptr        <= ptrUp;
        ras[ptrUp] <= bus.callRetAddrIn;
        cnt        <= cnt == FULL ? cnt : cnt + (PW + 1)'(1);
      end else if (pop && bus.callIn) begin
        ras[ptr] <= bus.callRetAddrIn;
      end else if (pop) begin
        ptr <= ptr - PW'(1);
        cnt <= cnt - (PW + 1)'(1);
      end
    end
  end
  assign bus.AddrOut         = pc;
  assign bus.EpcOut          = epc;
  assign bus.RasCountOut     = cnt;
  assign bus.RetPredTakenOut = retTaken;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plan plus randomized traffic checked against a queue-based reference model
module tb_pc_gen;
  localparam logic [31:0] MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] EXC  = 32'h8000_0180;
  logic clkIn = 1'b0;
  logic resetIn;
  int nChecks = 0;
  int nFails = 0;
  string phase = "init";
  logic [31:0] mPc, mEpc;
  logic mRt;
  logic [31:0] mRas[$];
  always #5 clkIn = ~clkIn;
  pc_gen_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();
  pc_gen #(
    .ADDR_W(32), .RESET_VEC(32'h0), .EXC_VEC(32'h8000_0180), .INST_BYTES(4), .RAS_DEPTH(4)
  ) dut (
    .clkIn(clkIn), .resetIn(resetIn), .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s.%s: got %h expected %h", phase, tag, obs, exp);
    end
  endtask
  task automatic idle();
    resetIn = 1'b0;
    bus.stallIn = 1'b0; bus.flushIn = 1'b0; bus.redirectAddrIn = '0;
    bus.excIn = 1'b0; bus.excEpcIn = '0; bus.eretIn = 1'b0;
    bus.callIn = 1'b0; bus.callRetAddrIn = '0; bus.retPredIn = 1'b0;
  endtask
  task automatic model();
    logic take;
    take = 1'b0;
    if (resetIn) begin
      mPc = 32'h0; mEpc = 32'h0; mRas.delete();
    end else if (bus.excIn) begin
      mPc = EXC & MASK; mEpc = bus.excEpcIn; mRas.delete();
    end else if (bus.eretIn) mPc = mEpc & MASK;
    else if (bus.flushIn) mPc = bus.redirectAddrIn & MASK;
    else if (!bus.stallIn) begin
      take = bus.retPredIn && mRas.size() > 0;
      if (take) begin
        mPc = mRas[$] & MASK;
        void'(mRas.pop_back());
      end else mPc = mPc + 32'd4;
      if (bus.callIn) begin
        mRas.push_back(bus.callRetAddrIn);
        if (mRas.size() > 4) void'(mRas.pop_front());
      end
    end
    mRt = take;
  endtask
  task automatic tick();
    @(posedge clkIn);
    model();
    #1;
    check("addr", bus.AddrOut, mPc);
    check("epc", bus.EpcOut, mEpc);
    check("cnt", 32'(bus.RasCountOut), 32'(mRas.size()));
    check("rtaken", 32'(bus.RetPredTakenOut), 32'(mRt));
  endtask
  task automatic call(input logic [31:0] a);
    idle(); bus.callIn = 1'b1; bus.callRetAddrIn = a; tick();
  endtask
  task automatic ret();
    idle(); bus.retPredIn = 1'b1; tick();
  endtask
  initial begin
    idle();
    phase = "reset";
    resetIn = 1'b1;
    tick(); tick();
    check("rst_addr", bus.AddrOut, 32'h0);
    idle();
    phase = "seq";
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_step", bus.AddrOut, 32'(i * 4));
    end
    phase = "stall";
    for (int i = 0; i < 3; i++) begin
      bus.stallIn = 1'b1; tick();
      check("held", bus.AddrOut, 32'h10);
    end
    bus.flushIn = 1'b1; bus.redirectAddrIn = 32'h203; tick();
    check("flush_align", bus.AddrOut, 32'h200);
    phase = "wrap";
    idle(); bus.flushIn = 1'b1; bus.redirectAddrIn = 32'hFFFF_FFFC; tick();
    idle(); tick();
    check("wrap0", bus.AddrOut, 32'h0);
    phase = "exc";
    bus.excIn = 1'b1; bus.excEpcIn = 32'h44; bus.eretIn = 1'b1; bus.stallIn = 1'b1; tick();
    check("exc_addr", bus.AddrOut, EXC);
    check("exc_epc", bus.EpcOut, 32'h44);
    idle(); tick();
    bus.eretIn = 1'b1; tick();
    check("eret_addr", bus.AddrOut, 32'h44);
    phase = "ras";
    call(32'h100); call(32'h200); call(32'h300);
    check("cnt3", 32'(bus.RasCountOut), 32'd3);
    ret();
    check("pop1", bus.AddrOut, 32'h300);
    check("pop1_rt", 32'(bus.RetPredTakenOut), 32'd1);
    ret();
    check("pop2", bus.AddrOut, 32'h200);
    idle(); bus.stallIn = 1'b1; bus.retPredIn = 1'b1; tick();
    check("stall_pop", bus.AddrOut, 32'h200);
    check("stall_cnt", 32'(bus.RasCountOut), 32'd1);
    phase = "ovf";
    idle(); bus.excIn = 1'b1; bus.excEpcIn = 32'h44; tick();
    for (int i = 1; i <= 5; i++) call(32'(i * 16));
    check("full", 32'(bus.RasCountOut), 32'd4);
    for (int i = 5; i >= 2; i--) begin
      ret();
      check("ovf_pop", bus.AddrOut, 32'(i * 16));
    end
    ret();
    check("under_rt", 32'(bus.RetPredTakenOut), 32'd0);
    check("under_cnt", 32'(bus.RasCountOut), 32'd0);
    phase = "callret";
    call(32'h70); call(32'h80);
    idle(); bus.callIn = 1'b1; bus.callRetAddrIn = 32'h90; bus.retPredIn = 1'b1; tick();
    check("cr_addr", bus.AddrOut, 32'h80);
    check("cr_cnt", 32'(bus.RasCountOut), 32'd2);
    ret();
    check("cr_pop", bus.AddrOut, 32'h90);
    phase = "midrst";
    idle(); bus.excIn = 1'b1; bus.excEpcIn = 32'h44; tick();
    call(32'h500); call(32'h600); call(32'h700);
    idle(); resetIn = 1'b1; bus.callIn = 1'b1; bus.excIn = 1'b1; tick();
    check("mr_addr", bus.AddrOut, 32'h0);
    check("mr_epc", bus.EpcOut, 32'h0);
    check("mr_cnt", 32'(bus.RasCountOut), 32'd0);
    phase = "random";
    for (int i = 0; i < 600; i++) begin
      resetIn = ($urandom % 64) == 0;
      bus.excIn = ($urandom % 20) == 0;
      bus.eretIn = ($urandom % 16) == 0;
      bus.flushIn = ($urandom % 10) == 0;
      bus.stallIn = ($urandom % 6) == 0;
      bus.callIn = ($urandom % 3) == 0;
      bus.retPredIn = ($urandom % 3) == 0;
      bus.redirectAddrIn = $urandom;
      bus.excEpcIn = $urandom;
      bus.callRetAddrIn = $urandom;
      tick();
    end
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
